// File: rtl/alu_pipe_harness.sv
// Stimulus generator (LCG for A, LFSR for B, sweep/random op) driving a 16-op signed ALU
// with a configurable register pipeline, valid tag, and running result signature/count.
module alu_pipe_harness #(
    parameter int          data_width = 32,
    parameter int          pipe_depth = 2,
    parameter logic [31:0] seed_a     = 32'h0000_0005,
    parameter logic [31:0] seed_b     = 32'h0000_0003
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    output logic [data_width-1:0] R,
    output logic                  flag,
    output logic                  valid,
    output logic [3:0]            op_out,
    output logic [data_width-1:0] sig,
    output logic [15:0]           count
);

    localparam int W    = data_width;
    localparam int SH_W = $clog2(data_width);
    localparam int LAST = pipe_depth - 1;

    localparam logic [W-1:0] lcg_mul = W'(32'h0019660D);
    localparam logic [W-1:0] lcg_inc = W'(32'h3C6EF35F);
    localparam logic [W-1:0] min_val = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] a_q, b_q, a_next, b_next;
    logic [3:0]   op_q, op_next;

    logic [W-1:0] r_pipe [pipe_depth];
    logic [W-1:0] r_in   [pipe_depth];
    logic [3:0]   op_pipe [pipe_depth];
    logic [3:0]   op_in   [pipe_depth];
    logic [pipe_depth-1:0] flag_pipe, flag_in, valid_pipe, valid_in;

    logic [W-1:0] sig_q;
    logic [15:0]  count_q;

    logic [W-1:0]    alu_r;
    logic            alu_flag;
    logic [SH_W-1:0] sh;
    logic [W-1:0]    sum, diff, neg;
    logic            lt, ovf, use_ovf;

    assign a_next  = a_q * lcg_mul + lcg_inc;
    assign b_next  = {b_q[W-2:0], b_q[W-1] ^ b_q[W-2]};
    assign op_next = mode ? (a_next[3:0] ^ b_next[3:0]) : op_q + 4'd1;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        sh       = b_q[SH_W-1:0];
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        neg      = -a_q;
        lt       = $signed(a_q) < $signed(b_q);
        alu_r    = '0;
        ovf      = 1'b0;
        use_ovf  = 1'b0;
        case (op_q)
            4'd0: begin
                alu_r   = sum;
                use_ovf = 1'b1;
                ovf     = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
            end
            4'd1: begin
                alu_r   = diff;
                use_ovf = 1'b1;
                ovf     = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
            end
            4'd2:  alu_r = a_q & b_q;
            4'd3:  alu_r = a_q | b_q;
            4'd4:  alu_r = a_q ^ b_q;
            4'd5:  alu_r = ~a_q;
            4'd6:  alu_r = a_q << sh;
            4'd7:  alu_r = a_q >> sh;
            4'd8:  alu_r = $signed(a_q) >>> sh;
            4'd9:  alu_r = {{(W-1){1'b0}}, lt};
            4'd10: alu_r = lt ? a_q : b_q;
            4'd11: alu_r = lt ? b_q : a_q;
            4'd12: alu_r = a_q;
            4'd13: alu_r = b_q;
            4'd14: begin
                alu_r   = neg;
                use_ovf = 1'b1;
                ovf     = (a_q == min_val);
            end
            default: begin
                alu_r   = a_q[W-1] ? neg : a_q;
                use_ovf = 1'b1;
                ovf     = (a_q == min_val);
            end
        endcase
        alu_flag = use_ovf ? ovf : (alu_r == '0);
    end

    // Input of each stage: the ALU for stage 0, the previous stage otherwise.
    for (genvar k = 0; k < pipe_depth; k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign r_in[k]     = alu_r;
            assign op_in[k]    = op_q;
            assign flag_in[k]  = alu_flag;
            assign valid_in[k] = 1'b1;
        end else begin : g_rest
            assign r_in[k]     = r_pipe[k-1];
            assign op_in[k]    = op_pipe[k-1];
            assign flag_in[k]  = flag_pipe[k-1];
            assign valid_in[k] = valid_pipe[k-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= W'(seed_a);
            b_q        <= W'(seed_b);
            op_q       <= 4'd0;
            // NOTE: the stage array is cleared on reset because a flushed pipe must read back as zero.
            for (int k = 0; k < pipe_depth; k++) begin
                r_pipe[k]  <= '0;
                op_pipe[k] <= 4'd0;
            end
            flag_pipe  <= '0;
            valid_pipe <= '0;
            sig_q      <= '0;
            count_q    <= 16'd0;
        end else if (en) begin
            a_q  <= a_next;
            b_q  <= b_next;
            op_q <= op_next;
            for (int k = 0; k < pipe_depth; k++) begin
                r_pipe[k]  <= r_in[k];
                op_pipe[k] <= op_in[k];
            end
            flag_pipe  <= flag_in;
            valid_pipe <= valid_in;
            if (valid_in[LAST]) begin
                sig_q   <= {sig_q[W-2:0], sig_q[W-1]} ^ r_in[LAST];
                count_q <= (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end
        end
    end

    assign R      = r_pipe[LAST];
    assign flag   = flag_pipe[LAST];
    assign valid  = valid_pipe[LAST];
    assign op_out = op_pipe[LAST];
    assign sig    = sig_q;
    assign count  = count_q;

endmodule

// File: tb/tb_alu_pipe_harness.sv
// Directed bench for alu_pipe_harness: four instances (8-bit depth 1/3, 8-bit overflow seeds,
// 32-bit depth 2 random-op) checked against hand values and a 64-bit reference model.
module tb_alu_pipe_harness;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n      = 0;

    logic [7:0]  r8, sig8, rovf, sigovf, r3, sig3;
    logic [31:0] r32, sig32;
    logic [3:0]  op8, opovf, op3, op32;
    logic        f8, v8, fovf, vovf, f3, v3, f32, v32;
    logic [15:0] c8, covf, c3, c32;
    logic [7:0]  r_first [11];

    alu_pipe_harness #(.data_width(8), .pipe_depth(1), .seed_a(32'h05), .seed_b(32'h03)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode(1'b0), .R(r8), .flag(f8), .valid(v8),
        .op_out(op8), .sig(sig8), .count(c8));

    alu_pipe_harness #(.data_width(8), .pipe_depth(1), .seed_a(32'h7F), .seed_b(32'h01)) uovf (
        .clk(clk), .rst(rst), .en(en), .mode(1'b0), .R(rovf), .flag(fovf), .valid(vovf),
        .op_out(opovf), .sig(sigovf), .count(covf));

    alu_pipe_harness #(.data_width(8), .pipe_depth(3), .seed_a(32'h05), .seed_b(32'h03)) u3 (
        .clk(clk), .rst(rst), .en(en), .mode(1'b0), .R(r3), .flag(f3), .valid(v3),
        .op_out(op3), .sig(sig3), .count(c3));

    alu_pipe_harness #(.data_width(32), .pipe_depth(2)) u32 (
        .clk(clk), .rst(rst), .en(en), .mode(1'b1), .R(r32), .flag(f32), .valid(v32),
        .op_out(op32), .sig(sig32), .count(c32));

    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint sx(input logic [63:0] x, input int w);
        logic [63:0] y;
        y = x & msk(w);
        if (y[w-1]) y = y | ~msk(w);
        return longint'(y);
    endfunction

    function automatic void alu_model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                                      input int w, output logic [63:0] r, output logic f);
        logic [63:0] m;
        longint sa, sb, full;
        int sh;
        m    = msk(w);
        sa   = sx(a, w);
        sb   = sx(b, w);
        sh   = int'(b & 64'(w - 1));
        full = 0;
        case (op)
            4'd0:  full = sa + sb;
            4'd1:  full = sa - sb;
            4'd14: full = -sa;
            4'd15: full = (sa < 0) ? -sa : sa;
            4'd2:  r = a & b & m;
            4'd3:  r = (a | b) & m;
            4'd4:  r = (a ^ b) & m;
            4'd5:  r = ~a & m;
            4'd6:  r = (a << sh) & m;
            4'd7:  r = (a & m) >> sh;
            4'd8:  r = 64'(sa >>> sh) & m;
            4'd9:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd10: r = ((sa < sb) ? a : b) & m;
            4'd11: r = ((sa < sb) ? b : a) & m;
            4'd12: r = a & m;
            default: r = b & m;
        endcase
        if (op inside {4'd0, 4'd1, 4'd14, 4'd15}) begin
            r = 64'(full) & m;
            f = (sx(r, w) != full);
        end else begin
            f = (r == 64'd0);
        end
    endfunction

    // Result number k (0-based) of a fresh generator run.
    function automatic void gen_result(input int w, input logic [63:0] sa, input logic [63:0] sb,
                                       input logic mode, input int k, output logic [63:0] r,
                                       output logic f, output logic [3:0] op);
        logic [63:0] a, b, m;
        m  = msk(w);
        a  = sa & m;
        b  = sb & m;
        op = 4'd0;
        for (int i = 0; i < k; i++) begin
            a  = (a * 64'h19660D + 64'h3C6EF35F) & m;
            b  = ((b << 1) | 64'(b[w-1] ^ b[w-2])) & m;
            op = mode ? (a[3:0] ^ b[3:0]) : op + 4'd1;
        end
        alu_model(a, b, op, w, r, f);
    endfunction

    function automatic logic [63:0] exp_sig(input int w, input logic [63:0] sa, input logic [63:0] sb,
                                            input logic mode, input int cnt);
        logic [63:0] s, r, m;
        logic f;
        logic [3:0] op;
        m = msk(w);
        s = 64'd0;
        for (int i = 0; i < cnt; i++) begin
            gen_result(w, sa, sb, mode, i, r, f, op);
            s = (((s << 1) | ((s >> (w - 1)) & 64'd1)) & m) ^ r;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_model(input string tag, input int w, input int d, input logic [63:0] sa,
                               input logic [63:0] sb, input logic mode, input logic [63:0] r_o,
                               input logic f_o, input logic [3:0] op_o, input logic v_o,
                               input logic [63:0] sig_o, input logic [15:0] c_o);
        int nres;
        logic [63:0] r;
        logic f;
        logic [3:0] op;
        nres = (n >= d) ? n - d + 1 : 0;
        r = 64'd0; f = 1'b0; op = 4'd0;
        if (nres > 0) gen_result(w, sa, sb, mode, nres - 1, r, f, op);
        check($sformatf("%s.R n=%0d", tag, n), r_o, r);
        check($sformatf("%s.flag n=%0d", tag, n), 64'(f_o), 64'(f));
        check($sformatf("%s.op_out n=%0d", tag, n), 64'(op_o), 64'(op));
        check($sformatf("%s.valid n=%0d", tag, n), 64'(v_o), 64'(nres > 0));
        check($sformatf("%s.sig n=%0d", tag, n), sig_o, exp_sig(w, sa, sb, mode, nres));
        check($sformatf("%s.count n=%0d", tag, n), 64'(c_o), 64'((nres > 65535) ? 65535 : nres));
    endtask

    task automatic check_all();
        check_model("u8", 8, 1, 64'h05, 64'h03, 1'b0, 64'(r8), f8, op8, v8, 64'(sig8), c8);
        check_model("u3", 8, 3, 64'h05, 64'h03, 1'b0, 64'(r3), f3, op3, v3, 64'(sig3), c3);
        check_model("u32", 32, 2, 64'h05, 64'h03, 1'b1, 64'(r32), f32, op32, v32, 64'(sig32), c32);
    endtask

    // One clock; outputs are read 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        n   = 0;
        check_all();

        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 7) begin
                en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check_all();
                end
                en = 1'b1;
            end
            step();
            n++;
            check_all();
            r_first[n] = r8;
            if (n == 1) begin
                check("first R", 64'(r8), 64'h08);
                check("first op", 64'(op8), 64'h0);
                check("first flag", 64'(f8), 64'h0);
                check("first valid", 64'(v8), 64'h1);
                check("add ovf R", 64'(rovf), 64'h80);
                check("add ovf flag", 64'(fovf), 64'h1);
            end
            if (n == 2) begin
                check("second R", 64'(r8), 64'h9A);
                check("second op", 64'(op8), 64'h1);
                check("second flag", 64'(f8), 64'h0);
                check("second count", 64'(c8), 64'h2);
            end
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        n   = 0;
        check_all();
        check("reset valid", 64'(v8), 64'h0);

        for (int i = 1; i <= 66; i++) begin
            step();
            n++;
            check_all();
            if (n <= 10) check($sformatf("rerun R n=%0d", n), 64'(r8), 64'(r_first[n]));
        end

        en = 1'b0;
        step();
        force u8.count_q = 16'hFFFE;
        force uovf.a_q   = 8'h80;
        force uovf.op_q  = 4'd15;
        #1;
        release u8.count_q;
        release uovf.a_q;
        release uovf.op_q;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n++;
            if (i == 0) begin
                check("abs min R", 64'(rovf), 64'h80);
                check("abs min flag", 64'(fovf), 64'h1);
                check("abs min op", 64'(opovf), 64'hF);
            end
            check($sformatf("sat count %0d", i), 64'(c8), 64'hFFFF);
            check($sformatf("sat sig %0d", i), 64'(sig8), exp_sig(8, 64'h05, 64'h03, 1'b0, n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
